// File: rtl/reg_scoreboard_if.sv
// Decode/writeback-side bundle for the register hazard scoreboard.
// The master is the pipeline control; the slave is the scoreboard itself.
interface reg_scoreboard_if #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2
);
    logic                       issue_valid;
    logic [NUM_RD*ADDR_W-1:0]   issue_src_addr;
    logic [NUM_RD-1:0]          issue_src_used;
    logic                       issue_wr_en;
    logic [ADDR_W-1:0]          issue_wr_addr;
    logic                       wb_valid;
    logic [ADDR_W-1:0]          wb_addr;
    logic                       flush;
    logic                       stall;
    logic                       issue_fire;
    logic [NUM_REGS-1:0]        busy_vec;
    logic                       pending_any;
    logic                       err_overflow;
    logic                       err_underflow;

    modport master (
        output issue_valid, issue_src_addr, issue_src_used, issue_wr_en, issue_wr_addr,
        output wb_valid, wb_addr, flush,
        input  stall, issue_fire, busy_vec, pending_any, err_overflow, err_underflow
    );

    modport slave (
        input  issue_valid, issue_src_addr, issue_src_used, issue_wr_en, issue_wr_addr,
        input  wb_valid, wb_addr, flush,
        output stall, issue_fire, busy_vec, pending_any, err_overflow, err_underflow
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register hazard scoreboard: a saturating pending-write counter per register,
// combinational stall for decode, writeback bypass and flush.
module reg_scoreboard #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned CNT_W     = 2,
    parameter bit          ZERO_REG  = 1'b1,
    parameter bit          WB_BYPASS = 1'b1
) (
    input logic              clk,
    input logic              reset,
    reg_scoreboard_if.slave  sb
);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [CNT_W-1:0]    eff   [NUM_REGS];
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] wr_match;
    logic [NUM_REGS-1:0] dec;
    logic                rd_hazard;
    logic                wr_hazard;
    logic                udf_hit;
    logic                stall;
    logic                fire;

    // Hazard detection; register loops also filter out-of-range addresses.
    always_comb begin
        rd_hazard = 1'b0;
        wr_hazard = 1'b0;
        udf_hit   = 1'b0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            busy[r]     = (cnt_q[r] != '0);
            wb_hit[r]   = sb.wb_valid && (sb.wb_addr == ADDR_W'(r));
            eff[r]      = cnt_q[r] - CNT_W'(WB_BYPASS && wb_hit[r] && busy[r]);
            wr_match[r] = sb.issue_wr_en && (sb.issue_wr_addr == ADDR_W'(r))
                          && !(ZERO_REG && (r == 0));
            dec[r]      = wb_hit[r] && busy[r];
            for (int i = 0; i < int'(NUM_RD); i++) begin
                if (sb.issue_src_used[i] && (sb.issue_src_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r))
                    && (eff[r] != '0) && !(ZERO_REG && (r == 0))) begin
                    rd_hazard = 1'b1;
                end
            end
            if (wr_match[r] && (cnt_q[r] == CntMax)) begin
                wr_hazard = 1'b1;
            end
            if (wb_hit[r] && !busy[r]) begin
                udf_hit = 1'b1;
            end
        end
        stall = sb.issue_valid && !sb.flush && (rd_hazard || wr_hazard);
        fire  = sb.issue_valid && !stall && !sb.flush;
    end

    // Counter update: flush wins; inc and dec on the same register cancel.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (sb.flush) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                cnt_d[r] = '0;
            end
        end else begin
            if (udf_hit) begin
                udf_d = 1'b1;
            end
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                if (fire && wr_match[r] && !dec[r]) begin
                    if (cnt_q[r] == CntMax) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d[r] = cnt_q[r] + 1'b1;
                    end
                end else if (dec[r] && !(fire && wr_match[r])) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                cnt_q[r] <= '0;
            end
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign sb.stall         = stall;
    assign sb.issue_fire    = fire;
    assign sb.busy_vec      = busy;
    assign sb.pending_any   = |busy;
    assign sb.err_overflow  = ovf_q;
    assign sb.err_underflow = udf_q;

endmodule
